memory_access_arbiter: RTL and testbench

MEMORY_ACCESS_ARBITER -- requirements
Module: memory_access_arbiter

---
 rtl/memory_access_arbiter.sv | 156 +++++++++++++++
 tb/tb_memory_access_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_arbiter.sv
// memory_access_arbiter: lets a serial command processor borrow the CPU's
// memory port. The CPU is paused (clock-enable inhibited), the bus is given a
// settling window, one word access is performed on the external path, and an
// ack is returned. A cooldown guarantees the CPU a minimum unpaused run time
// between consecutive external accesses.

package MemoryModesPackage;
  typedef enum logic [2:0] {
    ReadWriteMode_NONE = 3'd0,
    ReadWriteMode_BYTE = 3'd1,
    ReadWriteMode_HALF = 3'd2,
    ReadWriteMode_WORD = 3'd3
  } ReadWriteMode;
endpackage

module memory_access_arbiter
  import MemoryModesPackage::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int MIN_RUN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_req,
  input  logic        ext_write,
  input  logic [31:0] ext_address,
  input  logic [31:0] ext_data_in,
  output logic [31:0] ext_data_out,
  output logic        ext_ack,
  input  logic        cpu_busy,
  output logic        pause,
  output logic        mem_external,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic [2:0]  mem_read_mode,
  output logic [2:0]  mem_write_mode,
  input  logic [31:0] mem_data_in
);

  // The settle counter counts down to zero; the last PAUSING cycle is the one
  // where it reads zero, so SETTLE_CYCLES of 0 and 1 both give one cycle.
  localparam logic [7:0] settleLoad   = (SETTLE_CYCLES > 1) ? 8'(SETTLE_CYCLES - 1) : 8'd0;
  localparam logic [7:0] cooldownLoad = 8'(MIN_RUN_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    PAUSING,
    ACCESS,
    CAPTURE,
    ACK
  } ArbState;

  ArbState    state;
  logic [7:0] settleCount;
  logic [7:0] cooldownCount;
  logic       latchedWrite;

  // Arbitration FSM; every output is produced as a register alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every registered output is cleared by the async reset so an
      // access in flight is dropped at once, including any write strobe.
      state          <= IDLE;
      settleCount    <= 8'd0;
      cooldownCount  <= 8'd0;
      latchedWrite   <= 1'b0;
      pause          <= 1'b0;
      mem_external   <= 1'b0;
      ext_ack        <= 1'b0;
      mem_address    <= 32'd0;
      mem_data       <= 32'd0;
      ext_data_out   <= 32'd0;
      mem_read_mode  <= ReadWriteMode_NONE;
      mem_write_mode <= ReadWriteMode_NONE;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values and the default below is simply overridden where needed.
      ext_ack <= 1'b0;

      case (state)
        IDLE: begin
          pause          <= 1'b0;
          mem_external   <= 1'b0;
          mem_read_mode  <= ReadWriteMode_NONE;
          mem_write_mode <= ReadWriteMode_NONE;
          if (cooldownCount != 8'd0) begin
            cooldownCount <= cooldownCount - 8'd1;
          end else if (ext_req && !cpu_busy) begin
            state        <= PAUSING;
            pause        <= 1'b1;
            latchedWrite <= ext_write;
            mem_address  <= ext_address;
            mem_data     <= ext_data_in;
            settleCount  <= settleLoad;
          end
        end

        PAUSING: begin
          if (!ext_req) begin
            // Requester withdrew before the bus was taken: release the CPU.
            state         <= IDLE;
            pause         <= 1'b0;
            cooldownCount <= cooldownLoad;
          end else if (settleCount == 8'd0) begin
            state        <= ACCESS;
            mem_external <= 1'b1;
            if (latchedWrite) begin
              mem_write_mode <= ReadWriteMode_WORD;
            end else begin
              mem_read_mode <= ReadWriteMode_WORD;
            end
          end else begin
            settleCount <= settleCount - 8'd1;
          end
        end

        ACCESS: begin
          // Committed: ext_req is no longer consulted until the access acks.
          mem_write_mode <= ReadWriteMode_NONE;
          if (latchedWrite) begin
            state         <= ACK;
            mem_external  <= 1'b0;
            mem_read_mode <= ReadWriteMode_NONE;
            ext_ack       <= 1'b1;
          end else begin
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          // Memory read data is valid during this cycle.
          ext_data_out  <= mem_data_in;
          state         <= ACK;
          mem_external  <= 1'b0;
          mem_read_mode <= ReadWriteMode_NONE;
          ext_ack       <= 1'b1;
        end

        ACK: begin
          state         <= IDLE;
          pause         <= 1'b0;
          cooldownCount <= cooldownLoad;
        end

        default: begin
          state          <= IDLE;
          pause          <= 1'b0;
          mem_external   <= 1'b0;
          mem_read_mode  <= ReadWriteMode_NONE;
          mem_write_mode <= ReadWriteMode_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Scoreboard bench for memory_access_arbiter: scenarios push timed output
// expectations and expected acks; a negedge monitor pops and compares them.

module tb_memory_access_arbiter;
  import MemoryModesPackage::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ext_req = 1'b0;
  logic        ext_write = 1'b0;
  logic [31:0] ext_address = 32'd0;
  logic [31:0] ext_data_in = 32'd0;
  logic        cpu_busy = 1'b0;
  logic [31:0] mem_data_in = 32'd0;
  logic [31:0] ext_data_out;
  logic        ext_ack;
  logic        pause;
  logic        mem_external;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic [2:0]  mem_read_mode;
  logic [2:0]  mem_write_mode;

  memory_access_arbiter #(.SETTLE_CYCLES(2), .MIN_RUN_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ext_req(ext_req), .ext_write(ext_write),
    .ext_address(ext_address), .ext_data_in(ext_data_in),
    .ext_data_out(ext_data_out), .ext_ack(ext_ack),
    .cpu_busy(cpu_busy), .pause(pause), .mem_external(mem_external),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_read_mode(mem_read_mode), .mem_write_mode(mem_write_mode),
    .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {F_PAUSE, F_MEMEXT, F_ACK, F_WMODE, F_RMODE, F_ADDR, F_DATA, F_DOUT} FieldId;
  typedef struct {
    int          cyc;
    FieldId      field;
    logic [31:0] value;
    string       name;
  } Snap;
  typedef struct {
    int          cyc;
    logic [31:0] dout;
  } AckExp;

  Snap   snapQ[$];
  AckExp ackQ[$];
  int    passCount  = 0;
  int    checkCount = 0;

  localparam logic [31:0] NONE = 32'(ReadWriteMode_NONE);
  localparam logic [31:0] WORD = 32'(ReadWriteMode_WORD);

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Insert keeping the queue ordered by cycle.
  task automatic expectAt(input int c, input FieldId f, input logic [31:0] v, input string n);
    Snap s;
    int  idx;
    s.cyc = c; s.field = f; s.value = v; s.name = n;
    idx = snapQ.size();
    for (int i = 0; i < snapQ.size(); i++) begin
      if (snapQ[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    snapQ.insert(idx, s);
  endtask

  task automatic expectAck(input int c, input logic [31:0] dout);
    AckExp a;
    a.cyc = c; a.dout = dout;
    ackQ.push_back(a);
  endtask

  function automatic logic [31:0] fieldValue(input FieldId f);
    case (f)
      F_PAUSE:  return {31'd0, pause};
      F_MEMEXT: return {31'd0, mem_external};
      F_ACK:    return {31'd0, ext_ack};
      F_WMODE:  return {29'd0, mem_write_mode};
      F_RMODE:  return {29'd0, mem_read_mode};
      F_ADDR:   return mem_address;
      F_DATA:   return mem_data;
      default:  return ext_data_out;
    endcase
  endfunction

  // Monitor: compares due snapshots and every ack against the scoreboard.
  always @(negedge clk) begin
    AckExp a;
    while (snapQ.size() > 0 && snapQ[0].cyc <= cyc) begin
      check($sformatf("%s@%0d", snapQ[0].name, snapQ[0].cyc), fieldValue(snapQ[0].field), snapQ[0].value);
      void'(snapQ.pop_front());
    end
    if (ext_ack === 1'b1) begin
      if (ackQ.size() == 0) begin
        check($sformatf("unexpected_ack@%0d", cyc), 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        a = ackQ.pop_front();
        check("ack_cycle", 32'(cyc), 32'(a.cyc));
        check($sformatf("ack_dout@%0d", cyc), ext_data_out, a.dout);
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nextCycle();
  endtask

  // Word read; rdata is presented on mem_data_in only in cycle 4.
  task automatic readTxn(input logic [31:0] addr, input logic [31:0] rdata, input logic [31:0] prevDout);
    int b;
    b = cyc;
    ext_req = 1'b1; ext_write = 1'b0; ext_address = addr; ext_data_in = 32'h5555_5555;
    mem_data_in = 32'hBAD0_BAD0;
    expectAt(b,     F_PAUSE, 0, "rd_pause");
    for (int k = 1; k <= 5; k++) expectAt(b + k, F_PAUSE, 1, "rd_pause");
    expectAt(b + 6, F_PAUSE, 0, "rd_pause_release");
    expectAt(b + 2, F_MEMEXT, 0, "rd_memext");
    expectAt(b + 3, F_MEMEXT, 1, "rd_memext");
    expectAt(b + 4, F_MEMEXT, 1, "rd_memext_capture");
    expectAt(b + 5, F_MEMEXT, 0, "rd_memext");
    expectAt(b + 2, F_RMODE, NONE, "rd_rmode");
    expectAt(b + 3, F_RMODE, WORD, "rd_rmode");
    expectAt(b + 4, F_RMODE, WORD, "rd_rmode");
    expectAt(b + 5, F_RMODE, NONE, "rd_rmode");
    expectAt(b + 3, F_WMODE, NONE, "rd_wmode");
    expectAt(b + 3, F_ADDR, addr, "rd_addr");
    expectAt(b + 4, F_ACK, 0, "rd_ack");
    expectAt(b + 4, F_DOUT, prevDout, "rd_dout_before");
    expectAt(b + 6, F_ACK, 0, "rd_ack_pulse");
    expectAck(b + 5, rdata);
    for (int k = 1; k <= 6; k++) begin
      nextCycle();
      if (k == 4) mem_data_in = rdata;
      if (k == 5) mem_data_in = 32'hBAD1_BAD1;
      if (k == 6) ext_req = 1'b0;
    end
  endtask

  int b;

  initial begin
    // Reset state
    nextCycle();
    b = cyc;
    expectAt(b, F_PAUSE, 0, "rst_pause");
    expectAt(b, F_MEMEXT, 0, "rst_memext");
    expectAt(b, F_ACK, 0, "rst_ack");
    expectAt(b, F_WMODE, NONE, "rst_wmode");
    expectAt(b, F_RMODE, NONE, "rst_rmode");
    expectAt(b, F_ADDR, 0, "rst_addr");
    expectAt(b, F_DATA, 0, "rst_data");
    expectAt(b, F_DOUT, 0, "rst_dout");
    nextCycle();
    rst = 1'b0;
    idle(2);

    // Read of 0x20
    readTxn(32'h20, 32'h1234_5678, 32'h0);
    idle(8);

    // Write 0xDEADBEEF to 0x10; read data must survive the write
    b = cyc;
    ext_req = 1'b1; ext_write = 1'b1; ext_address = 32'h10; ext_data_in = 32'hDEAD_BEEF;
    expectAt(b, F_PAUSE, 0, "wr_pause");
    for (int k = 1; k <= 4; k++) expectAt(b + k, F_PAUSE, 1, "wr_pause");
    expectAt(b + 5, F_PAUSE, 0, "wr_pause_release");
    expectAt(b + 2, F_MEMEXT, 0, "wr_memext");
    expectAt(b + 3, F_MEMEXT, 1, "wr_memext");
    expectAt(b + 4, F_MEMEXT, 0, "wr_memext");
    expectAt(b + 3, F_WMODE, WORD, "wr_wmode");
    expectAt(b + 4, F_WMODE, NONE, "wr_wmode");
    expectAt(b + 3, F_RMODE, NONE, "wr_rmode");
    expectAt(b + 3, F_ADDR, 32'h10, "wr_addr");
    expectAt(b + 3, F_DATA, 32'hDEAD_BEEF, "wr_data");
    expectAt(b + 5, F_ACK, 0, "wr_ack_pulse");
    expectAck(b + 4, 32'h1234_5678);
    idle(5);
    ext_req = 1'b0;
    idle(8);

    // Cooldown: request held across the ack
    b = cyc;
    ext_req = 1'b1; ext_write = 1'b1; ext_address = 32'h40; ext_data_in = 32'hCAFE_F00D;
    expectAck(b + 4, 32'h1234_5678);
    for (int k = 5; k <= 9; k++) expectAt(b + k, F_PAUSE, 0, "cd_pause_idle");
    expectAt(b + 10, F_PAUSE, 1, "cd_pause_resume");
    expectAt(b + 11, F_MEMEXT, 0, "cd_memext");
    expectAt(b + 12, F_MEMEXT, 1, "cd_memext");
    expectAt(b + 12, F_DATA, 32'hCAFE_F00D, "cd_data");
    expectAck(b + 13, 32'h1234_5678);
    idle(14);
    ext_req = 1'b0;
    idle(8);

    // cpu_busy blocks the pause
    b = cyc;
    cpu_busy = 1'b1;
    ext_req = 1'b1; ext_write = 1'b1; ext_address = 32'h30; ext_data_in = 32'h0BAD_CAFE;
    for (int k = 0; k <= 6; k++) expectAt(b + k, F_PAUSE, 0, "busy_pause");
    expectAt(b + 7, F_PAUSE, 1, "busy_pause");
    expectAt(b + 8, F_MEMEXT, 0, "busy_memext");
    expectAt(b + 9, F_MEMEXT, 1, "busy_memext");
    expectAt(b + 9, F_ADDR, 32'h30, "busy_addr");
    expectAck(b + 10, 32'h1234_5678);
    for (int k = 1; k <= 11; k++) begin
      nextCycle();
      if (k == 6) cpu_busy = 1'b0;
      if (k == 11) ext_req = 1'b0;
    end
    idle(8);

    // Abort during PAUSING
    b = cyc;
    ext_req = 1'b1; ext_write = 1'b1; ext_address = 32'h50; ext_data_in = 32'h7777_7777;
    expectAt(b + 1, F_PAUSE, 1, "abort_pause");
    expectAt(b + 2, F_PAUSE, 1, "abort_pause");
    expectAt(b + 3, F_PAUSE, 0, "abort_release");
    for (int k = 0; k <= 8; k++) expectAt(b + k, F_MEMEXT, 0, "abort_memext");
    idle(2);
    ext_req = 1'b0;
    idle(10);

    // Reset during ACCESS, then a normal read
    b = cyc;
    ext_req = 1'b1; ext_write = 1'b1; ext_address = 32'h60; ext_data_in = 32'h1111_2222;
    expectAt(b + 2, F_PAUSE, 1, "rstmid_pause_before");
    expectAt(b + 3, F_PAUSE, 0, "rstmid_pause");
    expectAt(b + 3, F_MEMEXT, 0, "rstmid_memext");
    expectAt(b + 3, F_WMODE, NONE, "rstmid_wmode");
    expectAt(b + 3, F_ADDR, 0, "rstmid_addr");
    expectAt(b + 3, F_DATA, 0, "rstmid_data");
    expectAt(b + 3, F_DOUT, 0, "rstmid_dout");
    for (int k = 3; k <= 8; k++) expectAt(b + k, F_ACK, 0, "rstmid_noack");
    idle(3);
    rst = 1'b1;
    ext_req = 1'b0;
    nextCycle();
    rst = 1'b0;
    idle(5);
    readTxn(32'h70, 32'h89AB_CDEF, 32'h0);
    idle(8);

    check("scoreboard_drained", 32'(snapQ.size() + ackQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
